// File: rtl/mem_refill_arbiter.sv
// Round-robin arbiter multiplexing cache refill reads and write-backs onto one memory port.
// Optional macro ARB_WB_PRIORITY_EN lets write-back requests win arbitration over read-only requests.
module mem_refill_arbiter #(
  parameter int NUM_CH  = 2,
  parameter int ADDR_W  = 10,
  parameter int BLOCK_W = 128
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_CH-1:0]         ch_ren,
  input  logic [NUM_CH-1:0]         ch_wen,
  input  logic [NUM_CH*ADDR_W-1:0]  ch_addr,
  input  logic [NUM_CH*BLOCK_W-1:0] ch_din,
  output logic [NUM_CH-1:0]         ch_ready,
  output logic [NUM_CH-1:0]         ch_done,
  output logic [BLOCK_W-1:0]        rsp_dout,
  output logic                      busy,
  output logic                      mem_ren,
  output logic                      mem_wen,
  output logic [ADDR_W-1:0]         mem_block_address,
  output logic [BLOCK_W-1:0]        mem_din,
  input  logic                      mem_ready,
  input  logic                      mem_done,
  input  logic [BLOCK_W-1:0]        mem_dout
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [IDX_W-1:0] LAST_CH  = IDX_W'(NUM_CH - 1);
  localparam logic [IDX_W:0]   NUM_CH_W = (IDX_W + 1)'(NUM_CH);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t              state;
  logic [IDX_W-1:0]    rr_ptr;
  logic [IDX_W-1:0]    g_idx;
  logic [IDX_W:0]      pick;
  logic                grant_vld;
  logic [IDX_W-1:0]    grant_idx;
  logic                grant_wr;
  logic [ADDR_W-1:0]   sel_addr;
  logic [BLOCK_W-1:0]  sel_din;
  logic [NUM_CH-1:0]   g_onehot;

  // Returns {found, index} of the first set bit at or after ptr, wrapping circularly.
  function automatic logic [IDX_W:0] rr_pick(input logic [NUM_CH-1:0] req,
                                             input logic [IDX_W-1:0]  ptr);
    logic [2*NUM_CH-1:0] dbl;
    logic [NUM_CH-1:0]   rot;
    logic [IDX_W-1:0]    off;
    logic [IDX_W:0]      sum;
    logic                found;
    dbl   = {req, req};
    rot   = dbl[ptr +: NUM_CH];
    off   = '0;
    found = 1'b0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (rot[k]) begin
        found = 1'b1;
        off   = IDX_W'(k);
      end
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= NUM_CH_W) sum = sum - NUM_CH_W;
    return {found, sum[IDX_W-1:0]};
  endfunction

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    pick = rr_pick(ch_ren | ch_wen, rr_ptr);
`ifdef ARB_WB_PRIORITY_EN
    if (|ch_wen) pick = rr_pick(ch_wen, rr_ptr);
`endif
  end

  assign grant_vld = pick[IDX_W];
  assign grant_idx = pick[IDX_W-1:0];

  always_comb begin
    sel_addr = '0;
    sel_din  = '0;
    grant_wr = 1'b0;
    g_onehot = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant_idx == IDX_W'(i)) begin
        sel_addr = ch_addr[i*ADDR_W +: ADDR_W];
        sel_din  = ch_din[i*BLOCK_W +: BLOCK_W];
        grant_wr = ch_wen[i];
      end
      g_onehot[i] = (g_idx == IDX_W'(i));
    end
  end

  // A write-back always goes first; a read on the same channel is picked up on a later arbitration.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      // NOTE: the latched address/data are reset as well because they drive outputs directly.
      state             <= IDLE;
      rr_ptr            <= '0;
      g_idx             <= '0;
      busy              <= 1'b0;
      mem_ren           <= 1'b0;
      mem_wen           <= 1'b0;
      mem_block_address <= '0;
      mem_din           <= '0;
      ch_ready          <= '0;
      ch_done           <= '0;
      rsp_dout          <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
      case (state)
        IDLE: begin
          if (grant_vld) begin
            g_idx             <= grant_idx;
            mem_block_address <= sel_addr;
            mem_din           <= sel_din;
            mem_wen           <= grant_wr;
            mem_ren           <= !grant_wr;
            busy              <= 1'b1;
            state             <= grant_wr ? WRITE : READ;
          end
        end
        READ: begin
          if (mem_ready) begin
            mem_ren  <= 1'b0;
            rsp_dout <= mem_dout;
            ch_ready <= g_onehot;
            state    <= RESP;
          end
        end
        WRITE: begin
          if (mem_done) begin
            mem_wen <= 1'b0;
            ch_done <= g_onehot;
            state   <= RESP;
          end
        end
        RESP: begin
          ch_ready <= '0;
          ch_done  <= '0;
          busy     <= 1'b0;
          rr_ptr   <= (g_idx == LAST_CH) ? '0 : g_idx + IDX_W'(1);
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_refill_arbiter.md
MEM_REFILL_ARBITER -- requirements
Module: mem_refill_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of cache-miss requester channels (1..8).
REQ-002 SHALL have parameter ADDR_W, default 10, memory block-address width.
REQ-003 SHALL have parameter BLOCK_W, default 128, block data width in bits.
REQ-004 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port ch_ren  input  NUM_CH  per-channel block-read (refill) request, level.
REQ-007 SHALL have port ch_wen  input  NUM_CH  per-channel block-write (write-back) request, level.
REQ-008 SHALL have port ch_addr  input  NUM_CH*ADDR_W  per-channel block address; channel i occupies bits [i*ADDR_W +: ADDR_W].
REQ-009 SHALL have port ch_din  input  NUM_CH*BLOCK_W  per-channel write-back data, packed as ch_addr.
REQ-010 SHALL have port ch_ready  output  NUM_CH  one-cycle read-complete pulse to the granted channel.
REQ-011 SHALL have port ch_done  output  NUM_CH  one-cycle write-complete pulse to the granted channel.
REQ-012 SHALL have port rsp_dout  output  BLOCK_W  registered read data, valid while ch_ready is high.
REQ-013 SHALL have port busy  output  1  high in every state except IDLE.
REQ-014 SHALL have ports mem_ren, mem_wen (output, 1), mem_block_address (output, ADDR_W), mem_din (output, BLOCK_W), mem_ready, mem_done (input, 1), mem_dout (input, BLOCK_W): single shared memory port.

Function
REQ-015 SHALL implement FSM states IDLE, READ, WRITE, RESP; one memory transaction outstanding at most.
REQ-016 SHALL, in IDLE, grant the first channel with ch_ren|ch_wen set, searching circularly from rr_ptr; no request -> stay IDLE.
REQ-017 SHALL, for a granted channel with both ch_wen and ch_ren set, serve the write first; the read is re-arbitrated afterwards.
REQ-018 SHALL latch granted index, address and write data at the grant edge; subsequent channel input changes SHALL not affect the transaction.
REQ-019 SHALL assert mem_ren (READ) or mem_wen (WRITE) from the cycle after grant, held steady with latched address/data until mem_ready (READ) or mem_done (WRITE) is sampled high.
REQ-020 SHALL ignore mem_done in READ and mem_ready in WRITE.
REQ-021 SHALL, on completion, enter RESP for exactly one cycle: mem_ren/mem_wen low, ch_ready[g] or ch_done[g] high, rsp_dout = mem_dout captured at completion edge (read only; unchanged on writes).
REQ-022 SHALL set rr_ptr = (g+1) mod NUM_CH on leaving RESP, then return to IDLE; minimum transaction length 3 cycles (grant, 1 memory cycle, RESP).
REQ-023 SHALL require requesters to deassert within the cycle after their pulse; a request still high in IDLE is treated as new.
REQ-024 SHALL complete a transaction whose channel request drops mid-flight, still pulsing ch_ready/ch_done.
REQ-025 SHALL, for NUM_CH=1, behave identically with rr_ptr constant 0.
REQ-026 SHALL never assert more than one bit of ch_ready|ch_done, nor mem_ren and mem_wen together.

Reset
REQ-027 SHALL, on reset low (any cycle, including mid-transaction), immediately force IDLE, rr_ptr=0, all outputs 0, rsp_dout=0; aborted transactions produce no pulse.
REQ-028 SHALL begin arbitration on the first rising edge after reset deasserts.

Configuration
REQ-029 SHALL support macro ARB_WB_PRIORITY_EN: when defined, in IDLE any channel with ch_wen set wins over all read-only requests (circular search from rr_ptr among writers first); when undefined, pure round-robin per REQ-016.

Verification
REQ-030 Single read: ch_ren=01, ch_addr[0]=0x3A, mem_ready 4 cycles after mem_ren -> mem_block_address=0x3A, ch_ready=01 one cycle with rsp_dout=mem_dout, busy low next cycle.
REQ-031 Contention: ch_ren=11 held every IDLE -> grants alternate 0,1,0,1; never two pulses in one cycle.
REQ-032 Write-then-read: ch_wen[1]=1, ch_ren[1]=1, addr 0x10 -> mem_wen first, ch_done=10, then mem_ren, ch_ready=10.
REQ-033 ARB_WB_PRIORITY_EN defined, rr_ptr=0, ch_ren=01, ch_wen=10 -> channel 1 granted first; undefined -> channel 0 first.
REQ-034 Reset asserted during READ with mem_ren high -> mem_ren, busy, ch_ready drop immediately; after release, pending ch_ren re-granted from channel 0.
REQ-035 Stray mem_done during READ and request dropped mid-flight -> stays READ until mem_ready, then ch_ready still pulses.
